hazard_ctrl: RTL

- Pipeline control unit that consumes the ID/EX register's outputs and drives the per-stage enable and flush controls, including enable_ID_EX and flush_ID_EX.
- Detects load-use hazards, EX-resolved PC redirects, instruction and data memory waits, and halt.
- Drains the pipeline on halt, then asserts a sticky halt output.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline enable/flush/halt control with stall counter; define HAZARD_FORWARDING_EN when a forwarding unit exists
module hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_ID_EX,
  input  logic             WEN_ID_EX,
  input  logic [4:0]       wsel_ID_EX,
  input  logic             halt_ID_EX,
  input  logic             dREN_EX_MEM,
  input  logic             dWEN_EX_MEM,
  input  logic             WEN_EX_MEM,
  input  logic [4:0]       wsel_EX_MEM,
  input  logic [4:0]       Rs_IF_ID,
  input  logic [4:0]       Rt_IF_ID,
  input  logic             uses_rt_IF_ID,
  input  logic             pc_redirect_EX,
  output logic             pc_en,
  output logic             enable_IF_ID,
  output logic             flush_IF_ID,
  output logic             enable_ID_EX,
  output logic             flush_ID_EX,
  output logic             enable_EX_MEM,
  output logic             enable_MEM_WB,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
  state_t state, next_state;
  logic [DW-1:0] drain_cnt, next_drain;
  logic mem_busy, match_ex, use_hazard, count_stall;
  assign mem_busy = (dREN_EX_MEM | dWEN_EX_MEM) & ~dhit;
  assign match_ex = (wsel_ID_EX != 5'd0) &
                    (wsel_ID_EX == Rs_IF_ID | (uses_rt_IF_ID & wsel_ID_EX == Rt_IF_ID));
`ifdef HAZARD_FORWARDING_EN
  logic unused_fwd;
  assign unused_fwd = ^{WEN_EX_MEM, wsel_EX_MEM};
  assign use_hazard = dREN_ID_EX & WEN_ID_EX & match_ex;
`else
  logic match_mem;
  assign match_mem = (wsel_EX_MEM != 5'd0) &
                     (wsel_EX_MEM == Rs_IF_ID | (uses_rt_IF_ID & wsel_EX_MEM == Rt_IF_ID));
  assign use_hazard = (WEN_ID_EX & match_ex) | (WEN_EX_MEM & match_mem);
`endif
  // state, drain counter and saturating stall counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_drain;
      if (count_stall & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
    end
  end
  // next state and combinational stage controls
  always_comb begin
    next_state    = state;
    next_drain    = drain_cnt;
    pc_en         = ihit;
    enable_IF_ID  = 1'b1;
    flush_IF_ID   = 1'b0;
    enable_ID_EX  = 1'b1;
    flush_ID_EX   = 1'b0;
    enable_EX_MEM = 1'b1;
    enable_MEM_WB = 1'b1;
    halted        = 1'b0;
    count_stall   = 1'b0;
    case (state)
      RUN, MEM_WAIT: begin
        next_state = RUN;
        if (state == MEM_WAIT ? ~dhit : mem_busy) begin
          pc_en         = 1'b0;
          enable_IF_ID  = 1'b0;
          enable_ID_EX  = 1'b0;
          enable_EX_MEM = 1'b0;
          enable_MEM_WB = 1'b0;
          next_state    = MEM_WAIT;
        end else if (pc_redirect_EX) begin
          pc_en       = 1'b1;
          flush_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
        end else if (halt_ID_EX) begin
          pc_en       = 1'b0;
          flush_IF_ID = 1'b1;
          next_drain  = DW'(DRAIN_CYCLES);
          next_state  = DRAIN;
        end else if (use_hazard) begin
          pc_en        = 1'b0;
          enable_IF_ID = 1'b0;
          flush_ID_EX  = 1'b1;
        end else if (~ihit) begin
          flush_IF_ID = 1'b1;
        end
        count_stall = ~pc_en;
      end
      DRAIN: begin
        pc_en         = 1'b0;
        flush_IF_ID   = 1'b1;
        flush_ID_EX   = 1'b1;
        enable_EX_MEM = ~mem_busy;
        enable_MEM_WB = ~mem_busy;
        if (~mem_busy) begin
          next_drain = drain_cnt - 1'b1;
          next_state = drain_cnt == DW'(1) ? HALTED : DRAIN;
        end
      end
      default: begin
        pc_en         = 1'b0;
        enable_IF_ID  = 1'b0;
        enable_ID_EX  = 1'b0;
        enable_EX_MEM = 1'b0;
        enable_MEM_WB = 1'b0;
        halted        = 1'b1;
      end
    endcase
  end
endmodule
